bcd_conv_scheduler: RTL

- Shares one iterative binary-to-BCD engine (shift/add-3, one bit per clock) between NREQ value sources.
- Typical sources: frame counter, exposure, motor position.
- Arbitration is round-robin. Results go to the LCD text overlay with a valid/ready handshake.
- Replaces per-source combinational converters to save LUTs and ease timing on the LCD clock.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_dabble_step.sv | 23 ++
 rtl/bcd_conv_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD conversion scheduler
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic logic [63:0] pow10_minus1(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// rtl/bcd_dabble_step.sv - one shift/add-3 step of the binary-to-BCD engine
module bcd_dabble_step #(
    parameter int DIGITS = 6
) (
    input  logic [DIGITS*4-1:0] digits_in,
    input  logic                bit_in,
    output logic [DIGITS*4-1:0] digits_out
);

    logic [DIGITS*4-1:0] adj;

    // correct every digit >= 5 so the following shift carries into the next digit
    always_comb begin
        adj = digits_in;
        for (int d = 0; d < DIGITS; d++) begin
            if (digits_in[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = digits_in[d*4 +: 4] + 4'd3;
        end
    end

    // the carry out of the top digit falls off; the overflow flag already covers it
    assign digits_out = (adj << 1) | {{(DIGITS*4-1){1'b0}}, bit_in};

endmodule

// File: rtl/bcd_conv_scheduler.sv
// rtl/bcd_conv_scheduler.sv - round-robin sharing of one serial binary-to-BCD engine
module bcd_conv_scheduler
    import bcd_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int WIDTH  = 24,
    parameter int DIGITS = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_value,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     bcd_valid,
    input  logic                     bcd_ready,
    output logic [DIGITS*4-1:0]      bcd_digits,
    output logic [clog2(NREQ)-1:0]   bcd_id,
    output logic                     bcd_ovf
);

    localparam int          IDW    = clog2(NREQ);
    localparam int          CW     = clog2(WIDTH + 1);
    localparam logic [63:0] MAXVAL = pow10_minus1(DIGITS);

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, sel_q, pick;
    logic                 any_req;
    int                   idx;
    logic [WIDTH-1:0]     shreg_q, cap_value;
    logic [DIGITS*4-1:0]  acc_q, acc_step;
    logic                 ovf_q;
    logic [CW-1:0]        cnt_q;

    assign cap_value = req_value[sel_q*WIDTH +: WIDTH];

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .digits_in  (acc_q),
        .bit_in     (shreg_q[WIDTH-1]),
        .digits_out (acc_step)
    );

    // round-robin search: first requester at or after the pointer, wrapping
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = IDW'(idx);
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        grant     = '0;
        busy      = 1'b0;
        bcd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = LOAD;
            end
            LOAD: begin
                for (int k = 0; k < NREQ; k++) grant[k] = (sel_q == IDW'(k));
                busy    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == '0) state_d = HOLD;
            end
            HOLD: begin
                busy      = 1'b1;
                bcd_valid = 1'b1;
                if (bcd_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // selection, capture and serial conversion datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            sel_q   <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) sel_q <= pick;
                end
                LOAD: begin
                    shreg_q <= cap_value;
                    ovf_q   <= (64'(cap_value) > MAXVAL);
                    acc_q   <= '0;
                    cnt_q   <= CW'(WIDTH - 1);
                    ptr_q   <= (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
                end
                SHIFT: begin
                    acc_q   <= acc_step;
                    shreg_q <= shreg_q << 1;
                    cnt_q   <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bcd_digits = (state_q == HOLD) ? (ovf_q ? {DIGITS{BCD_NINE}} : acc_q) : '0;
    assign bcd_id     = (state_q == HOLD) ? sel_q : '0;
    assign bcd_ovf    = (state_q == HOLD) && ovf_q;

endmodule
